// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button debouncer: the per-channel
// FSM state encoding and a width helper used to size counters.
package btn_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // debounced level 0
        ST_PRESS_DB = 2'd1,  // counting consecutive high samples
        ST_HELD     = 2'd2,  // debounced level 1
        ST_REL_DB   = 2'd3   // counting consecutive low samples
    } btn_state_e;

    // Number of bits needed to hold 'value' (minimum 1), i.e. clog2(value+1)
    function automatic int unsigned calc_bw(input int unsigned value);
        int unsigned bw;
        bw = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= value) begin
                bw = i + 1;
            end else begin
                bw = bw;
            end
        end
        return bw;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, four-state debounce FSM with a
// stable-sample counter, and a registered one-cycle press pulse.
// Optional auto-repeat while held is built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int CNT_BW        = 3
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_btn,
    output logic level,
    output logic pulse
);

    // Last counter value before a level change is accepted
    localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(DB_CYCLES - 1);
    localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
    localparam logic [CNT_BW-1:0] CNT_ZERO = {CNT_BW{1'b0}};

    logic              sync1_r;
    logic              sync2_r;
    btn_state_e        state_r;
    btn_state_e        state_nxt_s;
    logic [CNT_BW-1:0] cnt_r;
    logic [CNT_BW-1:0] cnt_nxt_s;
    logic              level_r;
    logic              level_nxt_s;
    logic              rise_r;
    logic              rise_nxt_s;
    logic              rep_fire_s;
    logic              pulse_r;

    // Two-flop synchroniser for the raw asynchronous button level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_btn;
            sync2_r <= sync1_r;
        end
    end

    // Next-state logic: the sample that leaves a stable state already counts
    // as the first of the DB_CYCLES stable samples needed to switch level
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sync2_r) begin
                    state_nxt_s = ST_PRESS_DB;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_PRESS_DB: begin
                if (!sync2_r) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sync2_r) begin
                    state_nxt_s = ST_REL_DB;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_REL_DB: begin
                if (sync2_r) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, stable-sample counter, debounced level and press-pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                      REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_BW  = calc_bw(REP_MAX);
    localparam logic [REP_BW-1:0] REP_DELAY_V  = REP_BW'(REPEAT_DELAY);
    localparam logic [REP_BW-1:0] REP_PERIOD_V = REP_BW'(REPEAT_PERIOD);
    localparam logic [REP_BW-1:0] REP_ONE      = REP_BW'(1);
    localparam logic [REP_BW-1:0] REP_ZERO     = {REP_BW{1'b0}};

    logic [REP_BW-1:0] rep_cnt_r;
    logic [REP_BW-1:0] rep_cnt_nxt_s;
    logic              rep_first_r;
    logic              rep_first_nxt_s;

    // Repeat timer: runs only while staying in HELD; the first target is the
    // initial delay, later targets the repeat period
    always_comb begin
        rep_cnt_nxt_s   = rep_cnt_r;
        rep_first_nxt_s = rep_first_r;
        rep_fire_s      = 1'b0;
        if ((state_r == ST_HELD) && (state_nxt_s == ST_HELD)) begin
            if (rep_cnt_r == (rep_first_r ? REP_DELAY_V : REP_PERIOD_V)) begin
                rep_fire_s      = 1'b1;
                rep_cnt_nxt_s   = REP_ONE;
                rep_first_nxt_s = 1'b0;
            end else begin
                rep_cnt_nxt_s   = rep_cnt_r + REP_ONE;
            end
        end else begin
            rep_cnt_nxt_s   = REP_ZERO;
            rep_first_nxt_s = 1'b1;
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_r   <= REP_ZERO;
            rep_first_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_nxt_s;
            rep_first_r <= rep_first_nxt_s;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Output pulse: one cycle after a press is accepted, or on a repeat tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= rise_r | rep_fire_s;
        end
    end

    assign level = level_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/btn_debounce_multi.sv
// NUM_BTN independent debounce channels plus a lowest-index "any press"
// encoder over the registered press pulses. Defining BTN_AUTOREPEAT_EN adds
// per-channel auto-repeat pulses while a button stays held.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = 1000000,
    parameter int CNT_BW        = $clog2(DB_CYCLES + 1),
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int IDX_BW        = ($clog2(NUM_BTN) > 0) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_pulse,
    output logic               o_any,
    output logic [IDX_BW-1:0]  o_idx
);

    logic [IDX_BW-1:0] idx_s;

    // Reject configurations the channel logic cannot honour
    if ((NUM_BTN < 1) || (DB_CYCLES < 2) ||
        (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_cfg_err
        $error("btn_debounce_multi: illegal parameter set");
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .CNT_BW        (CNT_BW)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_btn (i_btn[g]),
            .level   (o_level[g]),
            .pulse   (o_pulse[g])
        );
    end

    // Priority encoder: scan from the top so the lowest pulsing index wins
    always_comb begin
        idx_s = {IDX_BW{1'b0}};
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (o_pulse[i]) begin
                idx_s = IDX_BW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign o_any = |o_pulse;
    assign o_idx = idx_s;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed and randomised checks for btn_debounce_multi with NUM_BTN=4,
// DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. The BTN_AUTOREPEAT_EN
// section only runs when that macro is defined.
module tb_btn_debounce_multi;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_pulse;
    logic          o_any;
    logic [1:0]    o_idx;

    int total_cnt;
    int bad_cnt;

    // Behavioural reference: sync pipe, per-channel run length of samples
    // disagreeing with the current level, and a pending press flag
    logic [NB-1:0] m_s1;
    logic [NB-1:0] m_s2;
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_pend;
    logic [NB-1:0] m_pulse;
    int            m_run [NB];

    btn_debounce_multi #(
        .NUM_BTN       (NB),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (i_btn),
        .o_level (o_level),
        .o_pulse (o_pulse),
        .o_any   (o_any),
        .o_idx   (o_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        m_level = '0;
        m_pend  = '0;
        m_pulse = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [NB-1:0] btn);
        m_pulse = m_pend;
        m_pend  = '0;
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = m_s2[i];
                    m_run[i]   = 0;
                    if (m_s2[i]) m_pend[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    function automatic int low_idx(input logic [NB-1:0] p);
        int r;
        r = 0;
        for (int i = NB - 1; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    // Expected pulse on a channel held from edge 1
    function automatic int held_pulse(input int e);
`ifdef BTN_AUTOREPEAT_EN
        return ((e == 7) || (e >= 27 && ((e - 27) % RP) == 0)) ? 1 : 0;
`else
        return (e == 7) ? 1 : 0;
`endif
    endfunction

    // Drive inputs on the falling edge, step the model at the rising edge,
    // and return just after it so outputs can be sampled
    task automatic cycle(input logic [NB-1:0] btn, input logic rst_v);
        @(negedge clk);
        i_btn   = btn;
        reset_n = rst_v;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step(btn);
        #1;
    endtask

    initial begin
        logic [NB-1:0] cur;
        logic [NB-1:0] bseq;
        int            seg [NB];

        total_cnt = 0;
        bad_cnt   = 0;
        i_btn     = '0;
        reset_n   = 1'b0;
        model_reset();

        // Reset state
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        check_val("rst_level", o_level, 0);
        check_val("rst_pulse", o_pulse, 0);
        check_val("rst_any",   o_any,   0);
        check_val("rst_idx",   o_idx,   0);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

        // Clean press on channel 0 held for 30 cycles
        for (int e = 1; e <= 30; e++) begin
            cycle(4'b0001, 1'b1);
            check_val("p0_level", o_level, (e >= 6) ? 1 : 0);
            check_val("p0_pulse", o_pulse, held_pulse(e));
            if (e == 7) begin
                check_val("p0_any", o_any, 1);
                check_val("p0_idx", o_idx, 0);
            end
        end
        for (int r = 1; r <= 10; r++) begin
            cycle(4'b0000, 1'b1);
            check_val("p0_rel_level", o_level, (r < 6) ? 1 : 0);
            check_val("p0_rel_pulse", o_pulse, 0);
        end

        // Channel 1: 3-cycle glitch is rejected
        for (int e = 1; e <= 14; e++) begin
            cycle((e <= 3) ? 4'b0010 : 4'b0000, 1'b1);
            check_val("g3_level", o_level, 0);
            check_val("g3_pulse", o_pulse, 0);
        end

        // Channel 1: exactly 4 high cycles is accepted, then released
        for (int e = 1; e <= 14; e++) begin
            cycle((e <= 4) ? 4'b0010 : 4'b0000, 1'b1);
            check_val("g4_level", o_level, (e >= 6 && e <= 9) ? 2 : 0);
            check_val("g4_pulse", o_pulse, (e == 7) ? 2 : 0);
        end

        // Channels 2 and 3 together, then a bouncy release
        for (int e = 1; e <= 12; e++) begin
            cycle(4'b1100, 1'b1);
            check_val("d23_level", o_level, (e >= 6) ? 12 : 0);
            check_val("d23_pulse", o_pulse, (e == 7) ? 12 : 0);
            if (e == 7) begin
                check_val("d23_any", o_any, 1);
                check_val("d23_idx", o_idx, 2);
            end
        end
        for (int r = 1; r <= 14; r++) begin
            bseq = (r == 3 || r == 4) ? 4'b1100 : 4'b0000;
            cycle(bseq, 1'b1);
            check_val("d23_rel_level", o_level, (r < 10) ? 12 : 0);
            check_val("d23_rel_pulse", o_pulse, 0);
        end

        // Reset while channel 3 is held and channel 0 is mid-debounce
        for (int e = 1; e <= 8; e++) cycle(4'b1000, 1'b1);
        for (int e = 1; e <= 4; e++) cycle(4'b1001, 1'b1);
        check_val("mr_pre_level", o_level, 8);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("mr_level", o_level, 0);
        check_val("mr_pulse", o_pulse, 0);
        check_val("mr_any",   o_any,   0);
        check_val("mr_idx",   o_idx,   0);
        cycle(4'b1001, 1'b0);
        cycle(4'b1001, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            cycle(4'b1001, 1'b1);
            check_val("mr_re_level", o_level, (e >= 6) ? 9 : 0);
            check_val("mr_re_pulse", o_pulse, (e == 7) ? 9 : 0);
            if (e == 7) begin
                check_val("mr_re_any", o_any, 1);
                check_val("mr_re_idx", o_idx, 0);
            end
        end
        for (int r = 1; r <= 10; r++) cycle(4'b0000, 1'b1);
        check_val("mr_settle", o_level, 0);

`ifdef BTN_AUTOREPEAT_EN
        // Long hold on channel 0 produces repeat pulses, release stops them
        for (int e = 1; e <= 60; e++) begin
            cycle(4'b0001, 1'b1);
            check_val("ar_pulse", o_pulse, held_pulse(e));
        end
        for (int r = 1; r <= 12; r++) begin
            cycle(4'b0000, 1'b1);
            check_val("ar_rel_pulse", o_pulse, 0);
        end
`endif

        // Random bounces on all channels against the reference model
        cur = i_btn;
        for (int i = 0; i < NB; i++) seg[i] = 0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (seg[i] == 0) begin
                    cur[i] = ~cur[i];
                    seg[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(5, 12));
                end
                seg[i]--;
            end
            cycle(cur, 1'b1);
            check_val("rnd_level", o_level, m_level);
`ifndef BTN_AUTOREPEAT_EN
            check_val("rnd_pulse", o_pulse, m_pulse);
            check_val("rnd_any",   o_any,   (m_pulse != '0) ? 1 : 0);
            check_val("rnd_idx",   o_idx,   low_idx(m_pulse));
`endif
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
